wb_arbiter: RTL

//  Shares one Wishbone slave port between NUM_MASTERS masters (e.g. fetch unit, LSU).
//  - Grants by round-robin and holds the grant for a whole bus cycle (CYC), plus LOCK extension.
//  - Routes the owner's request to the slave and the slave's response back to the owner only.
//  - A watchdog aborts hung transfers with an error to the owner.
//  - Sits between the core's bus masters and the system interconnect.

---
 rtl/wb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave, grant held for CYC and LOCK.
// Grant one cycle after CYC; losing masters stall with CYC high; a watchdog aborts stuck STB with ERR.
module wb_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 64
) (
  input  logic                            clk,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS-1:0]          m_lock_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  output logic [DATA_W-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS-1:0]          m_rty_o,
  output logic [NUM_MASTERS-1:0]          m_gnt_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic                            s_lock_o,
  output logic [ADDR_W-1:0]               s_adr_o,
  output logic [DATA_W-1:0]               s_dat_o,
  output logic [DATA_W/8-1:0]             s_sel_o,
  input  logic [DATA_W-1:0]               s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  input  logic                            s_rty_i,
  output logic [$clog2(NUM_MASTERS)-1:0]  owner_o,
  output logic                            busy_o
);
  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             pick_vld;
  logic [WD_W-1:0]  wd_cnt;

  logic [ADDR_W-1:0] adr_arr [NUM_MASTERS];
  logic [DATA_W-1:0] dat_arr [NUM_MASTERS];
  logic [SEL_W-1:0]  sel_arr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign adr_arr[k] = m_adr_i[k*ADDR_W +: ADDR_W];
    assign dat_arr[k] = m_dat_i[k*DATA_W +: DATA_W];
    assign sel_arr[k] = m_sel_i[k*SEL_W +: SEL_W];
  end

  // First requester after the last owner, wrapping, so every master gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!pick_vld && m_cyc_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  logic own_cyc, own_stb, own_lock, resp, release_ok, expire;
  assign own_cyc    = m_cyc_i[owner];
  assign own_stb    = m_stb_i[owner];
  assign own_lock   = m_lock_i[owner];
  assign resp       = s_ack_i | s_err_i | s_rty_i;
  assign release_ok = !own_cyc && !own_lock;
  // A response in the expiry cycle still wins: expire requires !resp.
  assign expire     = (TIMEOUT != 0) && own_stb && !resp && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_lock_o = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;
    case (state)
      BUSY: begin
        s_cyc_o        = own_cyc;
        s_stb_o        = own_stb;
        s_we_o         = m_we_i[owner];
        s_lock_o       = own_lock;
        s_adr_o        = adr_arr[owner];
        s_dat_o        = dat_arr[owner];
        s_sel_o        = sel_arr[owner];
        m_ack_o[owner] = s_ack_i;
        m_err_o[owner] = s_err_i;
        m_rty_o[owner] = s_rty_i;
      end
      ABORT:   m_err_o[owner] = 1'b1;
      default: ;
    endcase
  end

  assign m_dat_o = s_dat_i;
  assign busy_o  = (state == BUSY);
  assign owner_o = owner;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= IDX_W'(NUM_MASTERS - 1);
      wd_cnt  <= '0;
      m_gnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (pick_vld) begin
            owner   <= pick_idx;
            m_gnt_o <= NUM_MASTERS'(1) << pick_idx;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (release_ok) begin
            rr_ptr  <= owner;
            m_gnt_o <= '0;
            wd_cnt  <= '0;
            state   <= IDLE;
          end else if (expire) begin
            wd_cnt <= '0;
            state  <= ABORT;
          end else if ((TIMEOUT != 0) && own_stb && !resp) begin
            wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        default: begin
          rr_ptr  <= owner;
          m_gnt_o <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule
